// File: rtl/seg_hex_display.sv
// Multi-digit hex seven-segment controller with blink and leading-zero blanking.
// Define SEG_SCAN_EN to add the time-multiplexed scan_seg/scan_an outputs.
module seg_hex_display #(
    parameter int DIGITS  = 8,
    parameter int BLINK_W = 24,
    parameter int SCAN_W  = 16,
    localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDXW-1:0]       wr_idx,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic                  clear,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  lzb_en,
`ifdef SEG_SCAN_EN
    output logic [7:0]            scan_seg,
    output logic [DIGITS-1:0]     scan_an,
`endif
    output logic [DIGITS*8-1:0]   seg_out
);

    logic [3:0]          r_val [DIGITS];
    logic [DIGITS-1:0]   r_dp;
    logic [DIGITS-1:0]   r_valid;
    logic [BLINK_W-1:0]  r_blink;
    logic [DIGITS*8-1:0] r_seg;

    logic                w_idx_ok;
    logic                w_ok;
    logic [DIGITS-1:0]   w_lz;
    logic [7:0]          w_byte;
    logic [DIGITS*8-1:0] w_seg;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            4'hF: s = 7'b1000111;
        endcase
        return s;
    endfunction

    assign w_idx_ok = (32'(wr_idx) < DIGITS);
    assign seg_out  = r_seg;

    always_comb begin
        w_ok   = 1'b1;
        w_lz   = '0;
        w_seg  = '1;
        w_byte = 8'hFF;
        // Walk from the leftmost digit; w_ok means all digits above are blank-able.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_lz[i] = (i != 0) && (r_val[i] == 4'h0) && !r_dp[i] && w_ok;
            w_ok    = w_ok && (!r_valid[i] || w_lz[i]);
        end
        for (int i = 0; i < DIGITS; i++) begin
            w_byte = ~{dec7(r_val[i]), r_dp[i]};
            if (!r_valid[i] ||
                (blink_en[i] && r_blink[BLINK_W-1]) ||
                (lzb_en && w_lz[i]))
                w_byte = 8'hFF;
            w_seg[8*i +: 8] = w_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++)
                r_val[i] <= 4'h0;
            r_dp    <= '0;
            r_valid <= '0;
            r_blink <= '0;
            r_seg   <= '1;
        end else begin
            r_blink <= r_blink + 1'b1;
            r_seg   <= w_seg;
            if (clear) begin
                r_valid <= '0;
            end else if (wr_en && w_idx_ok) begin
                r_val[wr_idx]   <= wr_data;
                r_dp[wr_idx]    <= wr_dp;
                r_valid[wr_idx] <= 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_EN
    logic [SCAN_W-1:0] r_pre;
    logic [IDXW-1:0]   r_sidx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre    <= '0;
            r_sidx   <= '0;
            scan_seg <= 8'hFF;
            scan_an  <= '1;
        end else begin
            r_pre <= r_pre + 1'b1;
            if (r_pre == '1)
                r_sidx <= (r_sidx == IDXW'(DIGITS - 1)) ? '0 : r_sidx + 1'b1;
            scan_seg <= w_seg[8*r_sidx +: 8];
            scan_an  <= ~(DIGITS'(1) << r_sidx);
        end
    end
`endif

endmodule

// File: tb/tb_seg_hex_display.sv
// Self-checking bench for seg_hex_display: decode table, LZB, blink, clear/reset
// corner cases and randomized traffic against a behavioural model.
module tb_seg_hex_display;

    localparam int D  = 6;
    localparam int BW = 4;
    localparam int SW = 2;
    localparam int IW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [IW-1:0]  wr_idx;
    logic [3:0]     wr_data;
    logic           wr_dp;
    logic           clear;
    logic [D-1:0]   blink_en;
    logic           lzb_en;
    logic [D*8-1:0] seg_out;
`ifdef SEG_SCAN_EN
    logic [7:0]     scan_seg;
    logic [D-1:0]   scan_an;
`endif

    seg_hex_display #(.DIGITS(D), .BLINK_W(BW), .SCAN_W(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .wr_dp    (wr_dp),
        .clear    (clear),
        .blink_en (blink_en),
        .lzb_en   (lzb_en),
`ifdef SEG_SCAN_EN
        .scan_seg (scan_seg),
        .scan_an  (scan_an),
`endif
        .seg_out  (seg_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] dec_tbl [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic [3:0]     m_val [D];
    logic [D-1:0]   m_dp;
    logic [D-1:0]   m_valid;
    logic [BW-1:0]  m_blink;
    logic [D*8-1:0] m_seg;
    logic [D*8-1:0] m_next;
    int             m_pre;
    int             m_idx;
    logic [7:0]     m_scan_seg;
    logic [D-1:0]   m_an;

    function automatic logic [D*8-1:0] expect_seg();
        logic [D*8-1:0] r;
        logic           lz [D];
        logic           above;
        r = '1;
        for (int i = D - 1; i >= 0; i--) begin
            above = 1'b1;
            for (int j = i + 1; j < D; j++)
                if (m_valid[j] && !lz[j])
                    above = 1'b0;
            lz[i] = (i >= 1) && (m_val[i] == 0) && !m_dp[i] && above;
        end
        for (int i = 0; i < D; i++) begin
            if (!m_valid[i])
                r[8*i +: 8] = 8'hFF;
            else if (blink_en[i] && m_blink[BW-1])
                r[8*i +: 8] = 8'hFF;
            else if (lzb_en && lz[i])
                r[8*i +: 8] = 8'hFF;
            else
                r[8*i +: 8] = ~{dec_tbl[m_val[i]], m_dp[i]};
        end
        return r;
    endfunction

    always_comb m_next = expect_seg();

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++)
                m_val[i] <= 4'h0;
            m_dp       <= '0;
            m_valid    <= '0;
            m_blink    <= '0;
            m_seg      <= '1;
            m_pre      <= 0;
            m_idx      <= 0;
            m_scan_seg <= 8'hFF;
            m_an       <= '1;
        end else begin
            m_seg      <= m_next;
            m_scan_seg <= m_next[8*m_idx +: 8];
            m_an       <= ~(D'(1) << m_idx);
            m_pre      <= (m_pre + 1) % (1 << SW);
            if (m_pre == (1 << SW) - 1)
                m_idx <= (m_idx + 1) % D;
            m_blink <= m_blink + 1'b1;
            if (clear) begin
                m_valid <= '0;
            end else if (wr_en && int'(wr_idx) < D) begin
                m_val[wr_idx]   <= wr_data;
                m_dp[wr_idx]    <= wr_dp;
                m_valid[wr_idx] <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string name);
        chk(name, 64'(seg_out), 64'(m_seg));
`ifdef SEG_SCAN_EN
        chk({name, "_scan_seg"}, 64'(scan_seg), 64'(m_scan_seg));
        chk({name, "_scan_an"}, 64'(scan_an), 64'(m_an));
`endif
    endtask

    task automatic wr(input int idx, input logic [3:0] d, input logic dp);
        wr_idx  = IW'(idx);
        wr_data = d;
        wr_dp   = dp;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] data;
        logic       dp;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [16];

    localparam logic [D*8-1:0] ALL_DARK = '1;

    initial begin
        int lit, dark, run, max_run;
        logic [7:0] prev;

        vecs[0]  = '{4'h0, 1'b0, 8'h03};
        vecs[1]  = '{4'h1, 1'b1, 8'h9E};
        vecs[2]  = '{4'h2, 1'b0, 8'h25};
        vecs[3]  = '{4'h3, 1'b1, 8'h0C};
        vecs[4]  = '{4'h4, 1'b0, 8'h99};
        vecs[5]  = '{4'h5, 1'b1, 8'h48};
        vecs[6]  = '{4'h6, 1'b0, 8'h41};
        vecs[7]  = '{4'h7, 1'b1, 8'h1E};
        vecs[8]  = '{4'h8, 1'b0, 8'h01};
        vecs[9]  = '{4'h9, 1'b1, 8'h08};
        vecs[10] = '{4'hA, 1'b0, 8'h11};
        vecs[11] = '{4'hB, 1'b1, 8'hC0};
        vecs[12] = '{4'hC, 1'b0, 8'h63};
        vecs[13] = '{4'hD, 1'b1, 8'h84};
        vecs[14] = '{4'hE, 1'b0, 8'h61};
        vecs[15] = '{4'hF, 1'b1, 8'h70};

        rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0; wr_dp = 1'b0;
        clear = 1'b0; blink_en = '0; lzb_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_idle", 64'(seg_out), 64'(ALL_DARK));
        check_model("reset_model");

        wr(0, 4'hA, 1'b1);
        chk("first_write_d0", 64'(seg_out[7:0]), 64'h10);
        chk("first_write_rest", 64'(seg_out[D*8-1:8]), 64'(ALL_DARK[D*8-1:8]));

        for (int k = 0; k < 16; k++) begin
            wr(1, vecs[k].data, vecs[k].dp);
            chk($sformatf("decode_%0h", vecs[k].data),
                64'(seg_out[15:8]), 64'(vecs[k].exp));
            check_model("decode_model");
        end

        wr(D, 4'h3, 1'b0);
        chk("idx_eq_digits", 64'(seg_out), {32'hFFFF_FFFF, 8'h70, 8'h10});
        wr(7, 4'h2, 1'b0);
        chk("idx_max", 64'(seg_out), {32'hFFFF_FFFF, 8'h70, 8'h10});

        do_clear();
        chk("clear_all", 64'(seg_out), 64'(ALL_DARK));
        wr(3, 4'h0, 1'b0);
        wr(2, 4'h0, 1'b0);
        wr(1, 4'h7, 1'b0);
        wr(0, 4'h0, 1'b0);
        lzb_en = 1'b1;
        @(negedge clk);
        chk("lzb_on", 64'(seg_out), {16'hFFFF, 8'hFF, 8'hFF, 8'h1F, 8'h03});
        lzb_en = 1'b0;
        @(negedge clk);
        chk("lzb_off", 64'(seg_out), {16'hFFFF, 8'h03, 8'h03, 8'h1F, 8'h03});
        lzb_en = 1'b1;
        wr(2, 4'h0, 1'b1);
        chk("lzb_dp_stops", 64'(seg_out), {16'hFFFF, 8'hFF, 8'h02, 8'h1F, 8'h03});
        lzb_en = 1'b0;

        do_clear();
        wr(0, 4'h5, 1'b0);
        blink_en = 6'b000001;
        @(negedge clk);
        lit = 0; dark = 0; run = 0; max_run = 0; prev = 8'h00;
        for (int c = 0; c < 32; c++) begin
            check_model("blink_model");
            if (seg_out[7:0] == 8'h49) lit++;
            if (seg_out[7:0] == 8'hFF) dark++;
            run = (seg_out[7:0] == prev) ? run + 1 : 1;
            if (run > max_run) max_run = run;
            prev = seg_out[7:0];
            @(negedge clk);
        end
        chk("blink_lit", 64'(lit), 64'd16);
        chk("blink_dark", 64'(dark), 64'd16);
        chk("blink_run", 64'(max_run), 64'd8);
        blink_en = '0;

        wr(2, 4'h8, 1'b0);
        chk("pre_clr_wr", 64'(seg_out[23:16]), 64'h01);
        clear = 1'b1; wr_en = 1'b1; wr_idx = 3'd3; wr_data = 4'h1;
        @(negedge clk);
        clear = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        chk("clear_wins", 64'(seg_out), 64'(ALL_DARK));

        wr(4, 4'h2, 1'b0);
        chk("pre_rst_wr", 64'(seg_out[39:32]), 64'h25);
        wr_en = 1'b1; wr_idx = 3'd5; wr_data = 4'h9;
        #2 rst = 1'b1;
        #1 chk("rst_async", 64'(seg_out), 64'(ALL_DARK));
        @(negedge clk);
        wr_en = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_discard", 64'(seg_out), 64'(ALL_DARK));
        check_model("rst_model");

        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            check_model("scan_walk");
        end

        for (int c = 0; c < 400; c++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_idx   = IW'($urandom_range(0, 7));
            wr_data  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            wr_dp    = ($urandom_range(0, 3) == 0);
            clear    = ($urandom_range(0, 31) == 0);
            if (c % 16 == 0) begin
                lzb_en   = 1'($urandom_range(0, 1));
                blink_en = D'($urandom);
            end
            @(negedge clk);
            check_model("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_hex_display.md
Name: seg_hex_display

Overview:
- Parametrised multi-digit hexadecimal seven-segment display controller; successor to the fixed 3-bit-to-one-digit decoder.
- Holds one 4-bit value, a decimal point and a valid flag per digit.
- Decodes the full 0-F range, with per-digit blink and leading-zero blanking.
- Drives the board's parallel active-low segment outputs. Optionally also drives a time-multiplexed scan interface.

Parameters:
- DIGITS, 8, number of digits; legal range 1-16.
- BLINK_W, 24, width of the free-running blink counter; the blink phase is the counter MSB.
- SCAN_W, 16, width of the scan prescaler; used only with SEG_SCAN_EN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write one digit this cycle.
- wr_idx  input  IDXW=max(1,$clog2(DIGITS))  target digit; 0 = rightmost.
- wr_data  input  4  hex value to store.
- wr_dp  input  1  decimal point to store; 1 = lit.
- clear  input  1  synchronous clear of all digits (valid <= 0).
- blink_en  input  DIGITS  per-digit blink enable.
- lzb_en  input  1  leading-zero blanking enable.
- seg_out  output  DIGITS*8  digit i occupies [8i+7:8i]; bit7=a ... bit1=g, bit0=dp; active-low (0 = segment lit).
- scan_seg  output  8  (SEG_SCAN_EN only) segments of the currently scanned digit; same encoding as seg_out.
- scan_an  output  DIGITS  (SEG_SCAN_EN only) active-low digit select, one-hot-low.

Behaviour:
- Reset (async, rst=1):
  - all digit value=0, dp=0, valid=0.
  - blink counter=0.
  - seg_out all ones (all digits dark).
  - With SEG_SCAN_EN: scan index=0, prescaler=0, scan_seg=8'hFF, scan_an all ones.
- Reset mid-operation discards all stored digits immediately; there is no pending-write carry-over.
- Write:
  - On a clk edge with wr_en=1 and wr_idx<DIGITS: digit[wr_idx] <= {wr_data, wr_dp, valid=1}.
  - wr_idx>=DIGITS: write ignored, no state change.
- Clear: clear=1 sets every valid=0. On a simultaneous clear and wr_en, clear wins and the write is dropped.
- seg_out is registered. A write at edge N appears on seg_out after edge N+1; latency is 1 cycle from the write edge.
- Blink counter: free-running, increments every cycle, wraps from all-ones to 0.
- Decode, active-high a..g before inversion:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - dp appended as bit0. The byte is inverted for output.
- Blanking priority (digit output 8'hFF if any condition holds):
  1. valid=0.
  2. blink_en[i]=1 and blink MSB=1.
  3. lzb_en=1 and digit i is a leading zero.
- Leading zero definition: digit i (i>=1) is a leading zero when value=0, dp=0, and every digit j>i is either invalid or itself a leading zero. Digit 0 is never blanked by LZB.
- Blink blanks the dp too. Blink does not affect the LZB evaluation of other digits.

Optional Feature:
- Macro SEG_SCAN_EN.
- Defined:
  - Adds scan_seg and scan_an.
  - A SCAN_W-bit prescaler increments every cycle; on wrap to 0 the scan index advances: i -> i+1, DIGITS-1 -> 0.
  - scan_seg is the same byte as seg_out for the current index.
  - scan_an has only bit[index]=0.
  - Both outputs are registered and reflect the index one cycle after it changes.
  - seg_out is unaffected.
- Not defined: the scan ports and prescaler are absent; seg_out behaviour is identical.

Test Plan:
- Reset then idle 3 cycles -> seg_out all ones; blink counter 0 at release.
- Write wr_idx=0, wr_data=4'hA, wr_dp=1 -> one cycle later seg_out[7:0]=8'b0001_0000; other digits stay 8'hFF.
- Write all 16 values to digit 1 in sequence -> seg_out[15:8] matches the inverted decode table each cycle; wr_idx=DIGITS -> no change.
- Digits 3..0 = 0,0,7,0 (all valid), lzb_en=1 -> digits 3,2 = 8'hFF, digit 1 = 8'b0001_1111, digit 0 = 8'b0000_0011; lzb_en=0 -> digits 3,2 = 8'b0000_0011.
- BLINK_W=4, blink_en[0]=1, digit 0 = 5 -> seg_out[7:0] = 8'b0100_1001 for 8 cycles, then 8'hFF for 8 cycles, repeating.
- clear and wr_en together, then rst asserted mid-write -> all digits 8'hFF. With SEG_SCAN_EN, SCAN_W=2, DIGITS=4: scan_an walks 1110, 1101, 1011, 0111, each held 4 cycles, then wraps.
